// File: rtl/updn_cnt_sequencer_pkg.sv
// Shared types and default sizes for the up/down counter command sequencer.
package updn_seq_pkg;

  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_WIDTH   = 16;
  localparam int DEF_STEP_W  = 8;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_UP   = 2'b01,
    OP_DOWN = 2'b10,
    OP_READ = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_LOAD  = 2'b01,
    S_COUNT = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  // UP and DOWN are the only opcodes that drive the count enable.
  function automatic logic is_count_op(input op_e op);
    return (op == OP_UP) || (op == OP_DOWN);
  endfunction

endpackage

// File: rtl/updn_cnt_sequencer_if.sv
// Requester-side command handshake and completion report of the sequencer.
interface updn_cnt_sequencer_if
  import updn_seq_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0][1:0]       req_op;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_arg;
  logic                          done_valid;
  logic [IDW-1:0]                done_id;
  logic [WIDTH-1:0]              done_value;

  // Requesters drive commands and observe grants and completions.
  modport master (
    output req_valid, req_op, req_arg,
    input  req_ready, done_valid, done_id, done_value
  );

  // The sequencer consumes commands and reports completions.
  modport slave (
    input  req_valid, req_op, req_arg,
    output req_ready, done_valid, done_id, done_value
  );

endinterface

// File: rtl/updn_cnt_sequencer_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among requesters, search starts at the
// requester after the last one granted; the pointer moves only on a grant.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IDW    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDW-1:0]     grant_idx_o,
  output logic               grant_valid_o
);

  logic [IDW-1:0]     ptr_q;
  logic [IDW-1:0]     ptr_d;
  logic [NUM_REQ-1:0] grant_s;
  logic [IDW-1:0]     idx_s;
  logic               found_s;
  int                 k_s;

  // Pick the first requester at or after the pointer, wrapping around.
  always_comb begin
    grant_s = '0;
    idx_s   = '0;
    found_s = 1'b0;
    k_s     = 0;
    ptr_d   = ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      k_s = int'(ptr_q) + i;
      if (k_s >= NUM_REQ) begin
        k_s = k_s - NUM_REQ;
      end else begin
        k_s = k_s;
      end
      if (!found_s && en_i && req_i[k_s]) begin
        found_s = 1'b1;
        idx_s   = IDW'(k_s);
      end else begin
        found_s = found_s;
      end
    end
    grant_s[idx_s] = found_s;
    if (found_s) begin
      if (idx_s == IDW'(NUM_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = idx_s + IDW'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Priority pointer; requester 0 leads after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign grant_o       = grant_s;
  assign grant_idx_o   = idx_s;
  assign grant_valid_o = found_s;

endmodule

// File: rtl/updn_cnt_sequencer.sv
// Shares one external up/down counter among several requesters: accepts one
// command at a time, drives the counter pins, then reports the final value.
module updn_cnt_sequencer
  import updn_seq_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int STEP_W  = DEF_STEP_W
) (
  input  logic                 clk,
  input  logic                 rst,
  updn_cnt_sequencer_if.slave  bus,
  input  logic [WIDTH-1:0]     cnt_value,
  output logic [WIDTH-1:0]     cnt_data_in,
  output logic                 cnt_ld_n,
  output logic                 cnt_updn,
  output logic                 cnt_enb
);

  localparam int IDW = $clog2(NUM_REQ);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [WIDTH-1:0]   arg_q, arg_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [STEP_W-1:0]  rem_q, rem_d;
  logic               ld_n_q, ld_n_d;
  logic               updn_q, updn_d;
  logic               enb_q, enb_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               done_valid_q, done_valid_d;
  logic [IDW-1:0]     done_id_q, done_id_d;

  logic               arb_en_s;
  logic [NUM_REQ-1:0] grant_s;
  logic [IDW-1:0]     grant_idx_s;
  logic               grant_valid_s;
  op_e                sel_op_s;
  logic [WIDTH-1:0]   sel_arg_s;
  logic [STEP_W-1:0]  sel_steps_s;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk          (clk),
    .rst          (rst),
    .req_i        (bus.req_valid),
    .en_i         (arb_en_s),
    .grant_o      (grant_s),
    .grant_idx_o  (grant_idx_s),
    .grant_valid_o(grant_valid_s)
  );

  assign arb_en_s    = (state_q == S_IDLE);
  assign sel_op_s    = op_e'(bus.req_op[grant_idx_s]);
  assign sel_arg_s   = bus.req_arg[grant_idx_s];
  assign sel_steps_s = sel_arg_s[STEP_W-1:0];

  // Next state, command capture and the registered pin values for that state.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    arg_d   = arg_q;
    id_d    = id_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: begin
        if (grant_valid_s) begin
          op_d  = sel_op_s;
          arg_d = sel_arg_s;
          id_d  = grant_idx_s;
          rem_d = sel_steps_s;
          if (sel_op_s == OP_LOAD) begin
            state_d = S_LOAD;
          end else if (is_count_op(sel_op_s) && (sel_steps_s != '0)) begin
            state_d = S_COUNT;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        state_d = S_DONE;
      end
      S_COUNT: begin
        if (rem_q == STEP_W'(1)) begin
          state_d = S_DONE;
        end else begin
          rem_d = rem_q - STEP_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Pins are registered against the upcoming state so they line up with it.
    ld_n_d       = (state_d != S_LOAD);
    data_d       = (state_d == S_LOAD) ? arg_d : '0;
    enb_d        = (state_d == S_COUNT);
    done_valid_d = (state_d == S_DONE);
    if (state_d == S_COUNT) begin
      updn_d = (op_d == OP_UP);
    end else begin
      updn_d = updn_q;
    end
    if (state_d == S_DONE) begin
      done_id_d = id_d;
    end else begin
      done_id_d = done_id_q;
    end
  end

  // State, captured command and registered outputs; reset drops any command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= OP_LOAD;
      arg_q        <= '0;
      id_q         <= '0;
      rem_q        <= '0;
      ld_n_q       <= 1'b1;
      updn_q       <= 1'b0;
      enb_q        <= 1'b0;
      data_q       <= '0;
      done_valid_q <= 1'b0;
      done_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      arg_q        <= arg_d;
      id_q         <= id_d;
      rem_q        <= rem_d;
      ld_n_q       <= ld_n_d;
      updn_q       <= updn_d;
      enb_q        <= enb_d;
      data_q       <= data_d;
      done_valid_q <= done_valid_d;
      done_id_q    <= done_id_d;
    end
  end

  assign bus.req_ready  = grant_s;
  assign bus.done_valid = done_valid_q;
  assign bus.done_id    = done_id_q;
  assign bus.done_value = cnt_value;
  assign cnt_ld_n       = ld_n_q;
  assign cnt_updn       = updn_q;
  assign cnt_enb        = enb_q;
  assign cnt_data_in    = data_q;

endmodule

// File: tb/tb_updn_cnt_sequencer.sv
// Bench for updn_cnt_sequencer: models the external counter, predicts grants,
// pin activity, latency and results in a scoreboard checked on completion.
module tb_updn_cnt_sequencer;
  import updn_seq_pkg::*;

  localparam int N  = 2;
  localparam int W  = 16;
  localparam int SW = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] cnt_value = '0;
  logic [W-1:0] cnt_data_in;
  logic         cnt_ld_n;
  logic         cnt_updn;
  logic         cnt_enb;

  updn_cnt_sequencer_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

  updn_cnt_sequencer #(.NUM_REQ(N), .WIDTH(W), .STEP_W(SW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .cnt_value  (cnt_value),
    .cnt_data_in(cnt_data_in),
    .cnt_ld_n   (cnt_ld_n),
    .cnt_updn   (cnt_updn),
    .cnt_enb    (cnt_enb)
  );

  always #5 clk = ~clk;

  // External 16-bit up/down counter driven by the sequencer pins.
  always @(posedge clk) begin
    if (!cnt_ld_n) cnt_value <= cnt_data_in;
    else if (cnt_enb) cnt_value <= cnt_updn ? cnt_value + 16'd1 : cnt_value - 16'd1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         id;
    logic [W-1:0] val;
    int         due;
    int         ld_exp;
    int         en_exp;
    logic       dir;
    logic [W-1:0] ld_arg;
  } sb_t;

  typedef struct {
    int           id;
    logic [1:0]   op;
    logic [W-1:0] arg;
    logic [W-1:0] exp;
  } vec_t;

  sb_t          sb[$];
  int           grant_log[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_cnt = '0;
  int           exp_ptr = 0;
  int           ld_cnt = 0;
  int           en_cnt = 0;
  logic [W-1:0] last_done_val = '0;
  int           last_done_id = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin : mon
    int w, ew, steps;
    sb_t e;
    if (rst) begin
      sb.delete();
      exp_ptr = 0;
      ld_cnt  = 0;
      en_cnt  = 0;
    end else begin
      chk("ready_onehot", 32'($countones(bus.req_ready) <= 1), 32'd1);
      if (sb.size() != 0) chk("ready_in_flight", 32'(bus.req_ready), 32'd0);
      else chk("idle_pins", {15'd0, cnt_ld_n, cnt_enb, cnt_data_in}, {15'd0, 1'b1, 1'b0, 16'h0000});
      if (!cnt_ld_n) begin
        ld_cnt++;
        if (sb.size() != 0) chk("load_data", 32'(cnt_data_in), 32'(sb[0].ld_arg));
      end
      if (cnt_enb) begin
        en_cnt++;
        if (sb.size() != 0) chk("count_dir", 32'(cnt_updn), 32'(sb[0].dir));
      end
      if (bus.done_valid) begin
        if (sb.size() == 0) chk("spurious_done", 32'(sb.size()), 32'd1);
        else begin
          e = sb.pop_front();
          chk("done_id", 32'(bus.done_id), 32'(e.id));
          chk("done_value", 32'(bus.done_value), 32'(e.val));
          chk("done_latency", 32'(cyc), 32'(e.due));
          chk("ld_cycles", 32'(ld_cnt), 32'(e.ld_exp));
          chk("enb_cycles", 32'(en_cnt), 32'(e.en_exp));
          last_done_val = bus.done_value;
          last_done_id  = int'(bus.done_id);
        end
      end
      if ((bus.req_ready & bus.req_valid) != '0) begin
        w = 0;
        for (int i = 0; i < N; i++) if (bus.req_ready[i]) w = i;
        ew = -1;
        for (int i = 0; i < N; i++) if (ew < 0 && bus.req_valid[(exp_ptr + i) % N]) ew = (exp_ptr + i) % N;
        chk("rr_winner", 32'(w), 32'(ew));
        exp_ptr = (w + 1) % N;
        grant_log.push_back(w);
        steps    = int'(bus.req_arg[w][SW-1:0]);
        e.id     = w;
        e.dir    = 1'b0;
        e.ld_exp = 0;
        e.en_exp = 0;
        e.ld_arg = bus.req_arg[w];
        case (bus.req_op[w])
          2'b00: begin exp_cnt = bus.req_arg[w]; e.ld_exp = 1; e.due = cyc + 2; end
          2'b01, 2'b10: begin
            e.dir = (bus.req_op[w] == 2'b01);
            if (e.dir) exp_cnt = exp_cnt + W'(steps);
            else exp_cnt = exp_cnt - W'(steps);
            e.en_exp = steps;
            e.due = (steps == 0) ? cyc + 1 : cyc + steps + 1;
          end
          default: e.due = cyc + 1;
        endcase
        e.val  = exp_cnt;
        sb.push_back(e);
        ld_cnt = 0;
        en_cnt = 0;
      end
    end
  end

  task automatic issue(input int id, input logic [1:0] op, input logic [W-1:0] arg);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    bus.req_valid[id] = 1'b1;
    bus.req_op[id]    = op;
    bus.req_arg[id]   = arg;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (bus.req_ready[id]) got = 1'b1;
    end
    if (!got) chk("issue_ready", 32'(bus.req_ready[id]), 32'd1);
    @(posedge clk); #1;
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 400 && !idle; i++) begin
      @(posedge clk);
      if (sb.size() == 0) idle = 1'b1;
    end
    if (!idle) chk("idle_timeout", 32'(sb.size()), 32'd0);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
    chk({tag, "_ld_n"}, 32'(cnt_ld_n), 32'd1);
    chk({tag, "_enb"}, 32'(cnt_enb), 32'd0);
    chk({tag, "_updn"}, 32'(cnt_updn), 32'd0);
    chk({tag, "_data_in"}, 32'(cnt_data_in), 32'd0);
    chk({tag, "_done_valid"}, 32'(bus.done_valid), 32'd0);
    chk({tag, "_done_id"}, 32'(bus.done_id), 32'd0);
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{0, 2'b00, 16'h0005, 16'h0005};
    vecs[1]  = '{1, 2'b01, 16'h0003, 16'h0008};
    vecs[2]  = '{0, 2'b00, 16'h0001, 16'h0001};
    vecs[3]  = '{1, 2'b10, 16'h0003, 16'hFFFE};
    vecs[4]  = '{0, 2'b01, 16'h0002, 16'h0000};
    vecs[5]  = '{1, 2'b01, 16'h0000, 16'h0000};
    vecs[6]  = '{0, 2'b11, 16'hFFFF, 16'h0000};
    vecs[7]  = '{1, 2'b00, 16'hFFFF, 16'hFFFF};
    vecs[8]  = '{0, 2'b01, 16'h0001, 16'h0000};
    vecs[9]  = '{1, 2'b10, 16'hAB02, 16'hFFFE};
    vecs[10] = '{0, 2'b01, 16'h00FF, 16'h00FD};

    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_arg   = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // LOAD 0x1234 from req0 with explicit pin timing.
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b1;
    bus.req_op[0]    = 2'b00;
    bus.req_arg[0]   = 16'h1234;
    @(negedge clk);
    chk("load_grant", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    chk("load_ld_n_low", 32'(cnt_ld_n), 32'd0);
    chk("load_data_in", 32'(cnt_data_in), 32'h1234);
    chk("load_enb", 32'(cnt_enb), 32'd0);
    @(negedge clk);
    chk("load_ld_n_high", 32'(cnt_ld_n), 32'd1);
    chk("load_done_valid", 32'(bus.done_valid), 32'd1);
    chk("load_done_value", 32'(bus.done_value), 32'h1234);
    wait_idle();

    // Table-driven commands.
    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].id, vecs[i].op, vecs[i].arg);
      wait_idle();
      chk("vec_value", 32'(last_done_val), 32'(vecs[i].exp));
      chk("vec_id", 32'(last_done_id), 32'(vecs[i].id));
    end

    // Both requesters READ continuously: grants alternate starting with req1.
    grant_log.delete();
    @(posedge clk); #1;
    bus.req_op    = {2'b11, 2'b11};
    bus.req_valid = 2'b11;
    repeat (10) @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
    wait_idle();
    chk("alt_count", 32'(grant_log.size() >= 4), 32'd1);
    for (int i = 0; i < grant_log.size(); i++) chk("alt_order", 32'(grant_log[i]), 32'((i + 1) % 2));

    // Reset in the second COUNT cycle of UP 10.
    issue(1, 2'b00, 16'h0100);
    wait_idle();
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b1;
    bus.req_op[0]    = 2'b01;
    bus.req_arg[0]   = 16'h000A;
    @(negedge clk);
    chk("up10_grant", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midrst");
    repeat (12) @(posedge clk);
    #1;
    chk("midrst_counter_kept", 32'(cnt_value), 32'h0102);
    exp_cnt = 16'h0102;

    // Pointer back at req0: both valid, req0 first, then req1.
    bus.req_op    = {2'b11, 2'b11};
    bus.req_valid = 2'b11;
    @(negedge clk);
    chk("ptr_reset_grant", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    begin
      bit got;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        if (bus.req_ready[1]) got = 1'b1;
      end
      chk("ptr_second_grant", 32'(got), 32'd1);
    end
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    wait_idle();
    chk("ptr_last_id", 32'(last_done_id), 32'd1);
    chk("ptr_last_value", 32'(last_done_val), 32'h0102);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
